// File: rtl/lsu_ctrl.sv
// lsu_ctrl: single-outstanding load/store unit between the pipeline and a two-phase memory bus.
// Latency: store response 2 cycles after accept, load 3 cycles after accept with a zero-wait bus.
// Backpressure: req_ready is high only in IDLE; a stalled bus phase ends in an error after TIMEOUT_CYCLES.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   req_valid/req_ready           request handshake; access_type, addr, wdata sampled on accept
//   resp_valid, rdata, resp_err   one-cycle completion pulse; rdata/resp_err are 0 outside the pulse
//   mem_valid/mem_ready           bus address phase; mem_addr, mem_wen, mem_wstrb, mem_wdata held stable
//   mem_rvalid, mem_rdata         bus read-data phase
//
// Build option: LSU_MISALIGN_TRAP_EN -- when defined, misaligned half/word accesses complete with
// resp_err=1 and no bus cycle; when undefined, they are force-aligned and proceed normally.
//
// access_type codes: LB=0 LH=1 LW=2 LBU=4 LHU=5 SB=8 SH=9 SW=A, every other value is a no-op.

module lsu_ctrl #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  access_type,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        resp_valid,
  output logic [31:0] rdata,
  output logic        resp_err,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic        mem_wen,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  localparam logic [3:0] AT_LB  = 4'h0;
  localparam logic [3:0] AT_LH  = 4'h1;
  localparam logic [3:0] AT_LW  = 4'h2;
  localparam logic [3:0] AT_LBU = 4'h4;
  localparam logic [3:0] AT_LHU = 4'h5;
  localparam logic [3:0] AT_SB  = 4'h8;
  localparam logic [3:0] AT_SH  = 4'h9;
  localparam logic [3:0] AT_SW  = 4'hA;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  localparam logic [8:0] TMO = 9'(TIMEOUT_CYCLES);

`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_RDATA, S_RESP} state_t;
  state_t state;

  logic [7:0] cnt;
  logic [1:0] size_q;
  logic       sgn_q;
  logic [1:0] off_q;

  // Request decode, evaluated on the incoming request in IDLE.
  logic       in_legal;
  logic       in_store;
  logic       in_sgn;
  logic [1:0] in_size;
  logic [1:0] in_off;
  logic       in_misal;
  logic [3:0] in_strb;

  always_comb begin
    in_legal = 1'b1;
    in_store = 1'b0;
    in_sgn   = 1'b0;
    in_size  = SZ_B;
    case (access_type)
      AT_LB:   begin in_sgn = 1'b1; in_size = SZ_B; end
      AT_LH:   begin in_sgn = 1'b1; in_size = SZ_H; end
      AT_LW:   in_size = SZ_W;
      AT_LBU:  in_size = SZ_B;
      AT_LHU:  in_size = SZ_H;
      AT_SB:   begin in_store = 1'b1; in_size = SZ_B; end
      AT_SH:   begin in_store = 1'b1; in_size = SZ_H; end
      AT_SW:   begin in_store = 1'b1; in_size = SZ_W; end
      default: in_legal = 1'b0;
    endcase

    in_misal = ((in_size == SZ_H) && addr[0]) ||
               ((in_size == SZ_W) && (addr[1:0] != 2'b00));

    // Lane offset after force-alignment; only reaches the bus when the trap is not taken.
    case (in_size)
      SZ_H:    in_off = {addr[1], 1'b0};
      SZ_W:    in_off = 2'b00;
      default: in_off = addr[1:0];
    endcase

    case (in_size)
      SZ_H:    in_strb = 4'b0011 << in_off;
      SZ_W:    in_strb = 4'b1111;
      default: in_strb = 4'b0001 << in_off;
    endcase
  end

  // Load return path: move the addressed lane down to bit 0, then extend.
  logic [31:0] rd_shift;
  logic [31:0] rd_ext;

  assign rd_shift = mem_rdata >> {off_q, 3'b000};

  always_comb begin
    case (size_q)
      SZ_B:    rd_ext = {{24{sgn_q & rd_shift[7]}}, rd_shift[7:0]};
      SZ_H:    rd_ext = {{16{sgn_q & rd_shift[15]}}, rd_shift[15:0]};
      default: rd_ext = rd_shift;
    endcase
  end

  // Counter counts completed wait cycles in the current phase; expiry fires on the last allowed one.
  logic expired;
  assign expired = (({1'b0, cnt} + 9'd1) == TMO);

  // Combinational so that it is low throughout reset yet high in the very first cycle after it.
  assign req_ready = (state == S_IDLE) && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      size_q     <= SZ_B;
      sgn_q      <= 1'b0;
      off_q      <= 2'b00;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      rdata      <= '0;
      mem_valid  <= 1'b0;
      mem_wen    <= 1'b0;
      mem_wstrb  <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            size_q <= in_size;
            sgn_q  <= in_sgn;
            off_q  <= in_off;
            if (!in_legal) begin
              state      <= S_RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b0;
              rdata      <= '0;
            end else if (TRAP_EN && in_misal) begin
              state      <= S_RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              rdata      <= '0;
            end else begin
              state     <= S_ADDR;
              cnt       <= '0;
              mem_valid <= 1'b1;
              mem_addr  <= {addr[31:2], 2'b00};
              mem_wen   <= in_store;
              mem_wstrb <= in_store ? in_strb : 4'b0000;
              mem_wdata <= wdata << {in_off, 3'b000};
            end
          end
        end

        S_ADDR: begin
          // Handshake is checked first so it wins over a simultaneous expiry.
          if (mem_ready) begin
            mem_valid <= 1'b0;
            mem_wen   <= 1'b0;
            mem_wstrb <= '0;
            cnt       <= '0;
            // mem_wen still marks a store during the address phase.
            if (mem_wen) begin
              state      <= S_RESP;
              resp_valid <= 1'b1;
            end else begin
              state <= S_RDATA;
            end
          end else if (expired) begin
            mem_valid  <= 1'b0;
            mem_wen    <= 1'b0;
            mem_wstrb  <= '0;
            state      <= S_RESP;
            resp_valid <= 1'b1;
            resp_err   <= 1'b1;
            rdata      <= '0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end

        S_RDATA: begin
          if (mem_rvalid) begin
            rdata      <= rd_ext;
            resp_valid <= 1'b1;
            state      <= S_RESP;
          end else if (expired) begin
            rdata      <= '0;
            resp_err   <= 1'b1;
            resp_valid <= 1'b1;
            state      <= S_RESP;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end

        S_RESP: begin
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          rdata      <= '0;
          state      <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/lsu_ctrl.md
LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 255, is the bus wait limit in cycles per phase (range 1..255).
REQ-002 clk  in  1  single clock; all state updates on the rising edge.
REQ-003 rst  in  1  synchronous reset, active-high.
REQ-004 req_valid  in  1  pipeline presents a load/store.
REQ-005 req_ready  out  1  high only in IDLE; a request is accepted when req_valid && req_ready.
REQ-006 access_type  in  4  common-package load/store code (LB LH LW LBU LHU SB SH SW); any other code is a no-op.
REQ-007 addr  in  32  byte address; wdata  in  32  store data, right-aligned.
REQ-008 resp_valid  out  1  one-cycle completion pulse; rdata  out  32  extended load data; resp_err  out  1  misaligned or timed out.
REQ-009 mem_valid  out  1; mem_ready  in  1  bus address-phase handshake.
REQ-010 mem_addr  out  32  word-aligned ({addr[31:2],2'b00}); mem_wen  out  1; mem_wstrb  out  4; mem_wdata  out  32  lane-shifted.
REQ-011 mem_rvalid  in  1; mem_rdata  in  32  read-data phase.

Function
REQ-012 FSM states: IDLE, ADDR, RDATA, RESP.
REQ-013 IDLE: on acceptance, register access_type, addr, and wdata, then go to ADDR; a no-op code goes directly to RESP with resp_err=0 and rdata=0.
REQ-014 ADDR: hold mem_valid=1 and all mem_* outputs stable until mem_ready=1; then a store goes to RESP and a load goes to RDATA.
REQ-015 RDATA: wait for mem_rvalid=1, capture the extended data, then go to RESP; mem_rvalid in any other state is ignored.
REQ-016 RESP: assert resp_valid=1 for exactly one cycle, then go to IDLE; a new request is accepted no earlier than the cycle after RESP.
REQ-017 Latency with a zero-wait bus: store resp_valid is 2 cycles after acceptance; load resp_valid is 3 cycles after acceptance.
REQ-018 Byte strobe: off = addr[1:0]; byte ops use 4'b0001<<off, half ops use 4'b0011<<off, word ops use 4'b1111; mem_wstrb=0 for loads.
REQ-019 Store data: mem_wdata = wdata << (8*off); the bytes outside the strobe are don't-care.
REQ-020 Load data: shift mem_rdata right by 8*off, then apply extension.
REQ-021 Load extension: LB and LH sign-extend from bit 7 and bit 15; LBU and LHU zero-extend; LW passes the data through.
REQ-022 Timeout: a per-phase counter clears on entry to ADDR and to RDATA. If it reaches TIMEOUT_CYCLES, go to RESP with resp_err=1 and rdata=0, and drop mem_valid.
REQ-023 Simultaneous mem_ready and counter expiry: the handshake wins.
REQ-024 Outputs rdata and resp_err are valid only while resp_valid=1, and are held at 0 otherwise.

Reset
REQ-025 rst=1 forces IDLE, clears the counter, and sets outputs as follows: req_ready=0 during reset, mem_valid=0, mem_wen=0, mem_wstrb=0, resp_valid=0, resp_err=0, rdata=0, mem_addr=0, mem_wdata=0.
REQ-026 Reset asserted in mid-transaction abandons the access; no resp_valid is issued for it, and a late mem_rvalid after reset is ignored.
REQ-027 req_ready=1 in the first cycle after rst deasserts.

Configuration
REQ-028 Macro LSU_MISALIGN_TRAP_EN:
- Defined: a half access with addr[0]=1, or a word access with addr[1:0]!=0, issues no bus cycle and goes IDLE->RESP with resp_err=1 and rdata=0.
- Undefined: the address is force-aligned (half clears bit 0, word clears bits 1:0) and the access proceeds normally with resp_err=0.

Verification
REQ-029 SW addr=0x104 wdata=0xDEADBEEF, mem_ready=1 immediately -> mem_wstrb=4'hF, mem_addr=0x104, resp_valid 2 cycles after accept, resp_err=0.
REQ-030 SB addr=0x103 wdata=0x000000A5 -> mem_wstrb=4'b1000, mem_wdata[31:24]=0xA5, mem_wen=1.
REQ-031 LB addr=0x202, mem_rdata=0x12_80_34_56 -> rdata=0xFFFFFF80; the same access as LBU -> rdata=0x00000080.
REQ-032 LH addr=0x300, mem_ready delayed 3 cycles, mem_rvalid 2 cycles later, mem_rdata=0x0000F00D -> mem_valid held stable for 4 cycles, rdata=0xFFFFF00D.
REQ-033 LW with mem_ready never asserted, TIMEOUT_CYCLES=4 -> resp_valid=1, resp_err=1, rdata=0 after 4 wait cycles, then req_ready=1.
REQ-034 LW addr=0x402:
- With LSU_MISALIGN_TRAP_EN -> no mem_valid, resp_err=1 at 1 cycle after accept.
- Without the macro -> mem_addr=0x400, normal load.
- Plus rst pulsed in ADDR -> IDLE next cycle, no resp_valid.
